coef_plane_packer: RTL and testbench
====================================

// Module: coef_plane_packer
// PURPOSE
//  Serial-to-parallel packer, inverse of the bit-plane rotator feeding the multiplier.
//  - Accepts one W=2-bit polynomial coefficient per handshake, index 0 first.
//  - Assembles N coefficients into two bit-plane words: plane0 = coef bit0, plane1 = coef bit1.
//  - Sits at the multiplier output. Hands a packed polynomial downstream over valid/ready.
//  - Round trip: the planes it produces are in the same layout the rotator loads as data0/data1.
// PARAMETERS
//  N   4   coefficients per polynomial; also the plane word width (N >= 2)
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-high reset
//  start      in   1          1-cycle pulse: clear the planes and open a new frame
//  in_valid   in   1          in_coef is valid this cycle
//  in_ready   out  1          packer accepts a coefficient this cycle
//  in_coef    in   2          coefficient {bit1, bit0}
//  out_valid  out  1          plane0/plane1 hold a complete polynomial
//  out_ready  in   1          downstream accepts the polynomial
//  plane0     out  N          bit0 of coefficients; bit k = coef k
//  plane1     out  N          bit1 of coefficients; bit k = coef k
//  count      out  clog2(N+1) coefficients accepted in the current frame
//  busy       out  1          high in COLLECT or FULL
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE, plane0=plane1=0, count=0, in_ready=0, out_valid=0, busy=0.
//  All outputs are decoded from registers. No combinational path from any input to any output.
//  Accept: accept = in_valid & in_ready.
//   - On accept: plane0 <= {in_coef[0], plane0[N-1:1]}, plane1 <= {in_coef[1], plane1[N-1:1]}.
//   - Both planes shift right with MSB insert, so after N accepts coef k sits at bit k.
//   - count <= count + 1.
//  States:
//   IDLE
//    - in_ready=0, out_valid=0.
//    - start -> COLLECT; planes<=0, count<=0.
//    - in_valid is ignored.
//   COLLECT
//    - in_ready=1.
//    - accept with count==N-1 -> FULL. That edge writes the Nth coefficient and count<=N.
//    - out_valid=1 from the next cycle (1-cycle latency after the Nth accept).
//    - start -> abort: planes<=0, count<=0, stay in COLLECT. start wins over a same-cycle accept.
//   FULL
//    - out_valid=1, in_ready=0; planes and count are frozen.
//    - out_ready -> IDLE; planes keep their value, count<=0.
//    - out_ready & start in the same cycle -> COLLECT; planes<=0, count<=0.
//    - start without out_ready is ignored. A packed result is never dropped.
//  busy = (state != IDLE).
//  In COLLECT, plane0/plane1 show the partial shift contents; downstream must use them only while out_valid.
//  Reset mid-frame: immediate return to the reset values; the partial frame is discarded.
//  in_coef is don't-care when in_valid=0. count never exceeds N.
// TESTING
//  T1 Reset: assert reset mid-clock -> all outputs 0 at once; in_valid=1 in IDLE gives no shift.
//  T2 Basic, N=4: start, then coefs 1,2,3,0 on back-to-back cycles
//     -> out_valid high 1 cycle after the 4th accept; plane0=4'h5, plane1=4'h6, count=4.
//  T3 Gaps: same data with in_valid low 1-3 cycles between coefs
//     -> same planes; count increments only on accept.
//  T4 Backpressure: hold out_ready=0 for 5 cycles in FULL, drive in_valid=1 and start
//     -> planes stay 5/6, in_ready=0; one out_ready cycle -> IDLE.
//  T5 Abort: start, accept 2 coefs, start again, then feed 3,3,3,3
//     -> plane0=plane1=4'hF, count path 0->2->0->4.
//  T6 Round trip: load the rotator with data0=4'hA, data1=4'h3; feed its coef0 for 4 cycles
//     -> plane0=4'hA, plane1=4'h3. Randomised over 200 frames with a scoreboard.

Source files
------------

// File: rtl/coef_plane_packer.sv
// Serial-to-parallel coefficient packer: gathers N 2-bit coefficients
// into two bit-plane words and hands them downstream over valid/ready.
module coef_plane_packer #(
  parameter  int N  = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [1:0]    i_in_coef,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [N-1:0]  o_plane0,
  output logic [N-1:0]  o_plane1,
  output logic [CW-1:0] o_count,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_plane0;
  logic [N-1:0]  r_plane1;
  logic [N-1:0]  w_plane0_nxt;
  logic [N-1:0]  w_plane1_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_accept;
  logic          w_last;

  assign w_accept = i_in_valid & (r_state == COLLECT);
  assign w_last   = (r_count == CW'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_plane0 <= '0;
      r_plane1 <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_plane0 <= w_plane0_nxt;
      r_plane1 <= w_plane1_nxt;
      r_count  <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_plane0_nxt = r_plane0;
    w_plane1_nxt = r_plane1;
    w_count_nxt  = r_count;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt  = COLLECT;
          w_plane0_nxt = '0;
          w_plane1_nxt = '0;
          w_count_nxt  = '0;
        end
      end
      COLLECT: begin
        // An abort takes priority over a coefficient arriving alongside it
        if (i_start) begin
          w_plane0_nxt = '0;
          w_plane1_nxt = '0;
          w_count_nxt  = '0;
        end else if (w_accept) begin
          w_plane0_nxt = {i_in_coef[0], r_plane0[N-1:1]};
          w_plane1_nxt = {i_in_coef[1], r_plane1[N-1:1]};
          w_count_nxt  = r_count + 1'b1;
          if (w_last) w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (i_out_ready) begin
          w_count_nxt = '0;
          if (i_start) begin
            w_state_nxt  = COLLECT;
            w_plane0_nxt = '0;
            w_plane1_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_in_ready  = (r_state == COLLECT);
  assign o_out_valid = (r_state == FULL);
  assign o_busy      = (r_state != IDLE);
  assign o_plane0    = r_plane0;
  assign o_plane1    = r_plane1;
  assign o_count     = r_count;

endmodule

// File: tb/tb_coef_plane_packer.sv
// Directed and randomised checks for coef_plane_packer (N=4),
// including a round trip through a bit-plane rotator model.
module tb_coef_plane_packer;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk;
  logic          reset;
  logic          i_start;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [1:0]    i_in_coef;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [N-1:0]  o_plane0;
  logic [N-1:0]  o_plane1;
  logic [CW-1:0] o_count;
  logic          o_busy;

  int n_chk;
  int n_fail;

  coef_plane_packer #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_coef   (i_in_coef),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_plane0    (o_plane0),
    .o_plane1    (o_plane1),
    .o_count     (o_count),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [1:0] c, input int gap);
    int n;
    i_in_valid = 1'b0;
    repeat (gap) tick();
    i_in_valid = 1'b1;
    i_in_coef  = c;
    n = 0;
    while (!o_in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("in_ready_timeout", 32'(o_in_ready), 32'd1);
    tick();
    i_in_valid = 1'b0;
    i_in_coef  = 2'($urandom_range(3));
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!o_out_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("out_valid_timeout", 32'(o_out_valid), 32'd1);
  endtask

  task automatic release_out();
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
  endtask

  // Rotator model: coefficient k is {data1[k], data0[k]}
  function automatic logic [1:0] rot_coef(input logic [N-1:0] d0,
                                          input logic [N-1:0] d1,
                                          input int k);
    return {d1[k], d0[k]};
  endfunction

  initial begin
    logic [N-1:0] d0;
    logic [N-1:0] d1;
    logic [1:0]   seq [4];
    n_chk       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    i_start     = 1'b0;
    i_in_valid  = 1'b0;
    i_in_coef   = 2'd0;
    i_out_ready = 1'b0;

    // T1: reset values, IDLE ignores in_valid, async mid-frame reset
    #2;
    check("rst_busy",   32'(o_busy),      32'd0);
    check("rst_ovalid", 32'(o_out_valid), 32'd0);
    check("rst_iready", 32'(o_in_ready),  32'd0);
    check("rst_count",  32'(o_count),     32'd0);
    tick();
    reset = 1'b0;
    i_in_valid = 1'b1;
    i_in_coef  = 2'd3;
    repeat (3) tick();
    i_in_valid = 1'b0;
    check("idle_p0",    32'(o_plane0), 32'h0);
    check("idle_p1",    32'(o_plane1), 32'h0);
    check("idle_count", 32'(o_count),  32'd0);
    check("idle_busy",  32'(o_busy),   32'd0);
    pulse_start();
    send(2'd3, 0);
    send(2'd1, 0);
    check("pre_rst_count", 32'(o_count), 32'd2);
    #3;
    reset = 1'b1;
    #1;
    check("arst_count",  32'(o_count),    32'd0);
    check("arst_p0",     32'(o_plane0),   32'h0);
    check("arst_p1",     32'(o_plane1),   32'h0);
    check("arst_busy",   32'(o_busy),     32'd0);
    check("arst_iready", 32'(o_in_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // T2: back-to-back 1,2,3,0
    pulse_start();
    check("t2_busy",   32'(o_busy),     32'd1);
    check("t2_iready", 32'(o_in_ready), 32'd1);
    check("t2_count0", 32'(o_count),    32'd0);
    send(2'd1, 0);
    send(2'd2, 0);
    send(2'd3, 0);
    check("t2_count3", 32'(o_count),     32'd3);
    check("t2_ov_pre", 32'(o_out_valid), 32'd0);
    send(2'd0, 0);
    check("t2_ovalid", 32'(o_out_valid), 32'd1);
    check("t2_iready_full", 32'(o_in_ready), 32'd0);
    check("t2_p0",     32'(o_plane0),    32'h5);
    check("t2_p1",     32'(o_plane1),    32'h6);
    check("t2_count4", 32'(o_count),     32'd4);
    release_out();
    check("t2_idle_busy", 32'(o_busy),   32'd0);
    check("t2_idle_cnt",  32'(o_count),  32'd0);
    check("t2_keep_p0",   32'(o_plane0), 32'h5);
    check("t2_keep_p1",   32'(o_plane1), 32'h6);

    // T3: gaps between coefficients
    seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      i_in_valid = 1'b0;
      repeat (1 + i % 3) tick();
      check("t3_gap_cnt", 32'(o_count), 32'(i));
      send(seq[i], 0);
      if (i < 3) check("t3_cnt", 32'(o_count), 32'(i + 1));
    end
    wait_out_valid();
    check("t3_p0",  32'(o_plane0), 32'h5);
    check("t3_p1",  32'(o_plane1), 32'h6);
    check("t3_cnt4", 32'(o_count), 32'd4);

    // T4: backpressure in FULL with in_valid and start pressing
    i_in_valid = 1'b1;
    i_in_coef  = 2'd3;
    i_start    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_ovalid", 32'(o_out_valid), 32'd1);
      check("t4_iready", 32'(o_in_ready),  32'd0);
      check("t4_p0",     32'(o_plane0),    32'h5);
      check("t4_p1",     32'(o_plane1),    32'h6);
    end
    i_in_valid = 1'b0;
    i_start    = 1'b0;
    release_out();
    check("t4_idle", 32'(o_busy), 32'd0);

    // FULL with out_ready and start together goes straight to COLLECT
    pulse_start();
    for (int i = 0; i < 4; i++) send(seq[i], 0);
    i_start     = 1'b1;
    i_out_ready = 1'b1;
    tick();
    i_start     = 1'b0;
    i_out_ready = 1'b0;
    check("t4b_iready", 32'(o_in_ready), 32'd1);
    check("t4b_p0",     32'(o_plane0),   32'h0);
    check("t4b_cnt",    32'(o_count),    32'd0);

    // T5: abort mid-frame, start wins over a same-cycle accept
    send(2'd1, 0);
    send(2'd2, 0);
    check("t5_cnt2", 32'(o_count), 32'd2);
    i_start    = 1'b1;
    i_in_valid = 1'b1;
    i_in_coef  = 2'd3;
    tick();
    i_start    = 1'b0;
    i_in_valid = 1'b0;
    check("t5_cnt_abort", 32'(o_count),  32'd0);
    check("t5_p0_abort",  32'(o_plane0), 32'h0);
    check("t5_p1_abort",  32'(o_plane1), 32'h0);
    for (int i = 0; i < 4; i++) send(2'd3, 0);
    check("t5_ovalid", 32'(o_out_valid), 32'd1);
    check("t5_cnt4",   32'(o_count),     32'd4);
    check("t5_p0",     32'(o_plane0),    32'hF);
    check("t5_p1",     32'(o_plane1),    32'hF);
    release_out();

    // T6: round trip from the rotator, directed then randomised
    d0 = 4'hA;
    d1 = 4'h3;
    pulse_start();
    for (int k = 0; k < N; k++) send(rot_coef(d0, d1, k), 0);
    check("t6_p0", 32'(o_plane0), 32'hA);
    check("t6_p1", 32'(o_plane1), 32'h3);
    release_out();
    for (int f = 0; f < 200; f++) begin
      d0 = N'($urandom);
      d1 = N'($urandom);
      pulse_start();
      for (int k = 0; k < N; k++) send(rot_coef(d0, d1, k), $urandom_range(2));
      wait_out_valid();
      repeat ($urandom_range(2)) tick();
      check("rnd_p0", 32'(o_plane0), 32'(d0));
      check("rnd_p1", 32'(o_plane1), 32'(d1));
      release_out();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
